// File: rtl/bash_hash_params_pkg.sv
// Shared sizing constants and core-sequencer state type for the bash_hash
// streaming front-end.
package bash_hash_params_pkg;
  localparam int XLEN        = 32;
  localparam int SLEN        = 64;
  localparam int IN_WORDS    = 16 * SLEN / XLEN;
  localparam int OUT_WORDS   = 8 * SLEN / XLEN;
  localparam int CORE_CYCLES = 24;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {C_IDLE, C_WORK, C_OUT} core_st_e;
endpackage

// File: rtl/bash_hash_blk_buf.sv
// Two-entry block buffer: one entry fills from the word stream while the
// other is held for the core. Full/last flags gate both sides.
module bash_hash_blk_buf #(
  parameter int XLEN     = bash_hash_params_pkg::XLEN,
  parameter int IN_WORDS = bash_hash_params_pkg::IN_WORDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     wr_last,
  input  logic                     rd_done,
  output logic                     wr_full,
  output logic                     rd_full,
  output logic                     rd_last,
  output logic [IN_WORDS*XLEN-1:0] rd_blk
);
  localparam int IW = $clog2(IN_WORDS);

  logic [1:0][IN_WORDS*XLEN-1:0] blk_q;
  logic [1:0]                    full_q, last_q;
  logic                          wr_sel_q, rd_sel_q;
  logic [IW-1:0]                 wr_cnt_q;
  logic                          blk_done;

  assign blk_done = wr_en && (wr_last || wr_cnt_q == IW'(IN_WORDS - 1));
  assign wr_full  = full_q[wr_sel_q];
  assign rd_full  = full_q[rd_sel_q];
  assign rd_last  = last_q[rd_sel_q];
  assign rd_blk   = blk_q[rd_sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q    <= '0;
      full_q   <= '0;
      last_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        // A short final block is zero-padded so stale words never reach the core.
        for (int k = 0; k < IN_WORDS; k++) begin
          if (k == int'(wr_cnt_q))
            blk_q[wr_sel_q][k*XLEN +: XLEN] <= wr_data;
          else if (wr_last && k > int'(wr_cnt_q))
            blk_q[wr_sel_q][k*XLEN +: XLEN] <= '0;
        end
        if (blk_done) begin
          full_q[wr_sel_q] <= 1'b1;
          last_q[wr_sel_q] <= wr_last;
          wr_sel_q         <= ~wr_sel_q;
          wr_cnt_q         <= '0;
        end else begin
          wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end
      if (rd_done) begin
        full_q[rd_sel_q] <= 1'b0;
        last_q[rd_sel_q] <= 1'b0;
        rd_sel_q         <= ~rd_sel_q;
      end
    end
  end
endmodule

// File: rtl/bash_hash_stream_ctrl.sv
// Stream front-end and sequencer for bash_hash: word stream in, block
// double-buffering, core prep/start/work control, digest stream out.
module bash_hash_stream_ctrl #(
  parameter int XLEN        = bash_hash_params_pkg::XLEN,
  parameter int SLEN        = bash_hash_params_pkg::SLEN,
  parameter int IN_WORDS    = bash_hash_params_pkg::IN_WORDS,
  parameter int OUT_WORDS   = bash_hash_params_pkg::OUT_WORDS,
  parameter int CORE_CYCLES = bash_hash_params_pkg::CORE_CYCLES,
  parameter int CNT_W       = bash_hash_params_pkg::CNT_W
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic [XLEN-1:0]     cfg_l_i,
  input  logic [XLEN-1:0]     s_data_i,
  input  logic                s_valid_i,
  input  logic                s_last_i,
  output logic                s_ready_o,
  output logic [XLEN-1:0]     m_data_o,
  output logic                m_valid_o,
  output logic                m_last_o,
  input  logic                m_ready_i,
  output logic                core_prep_o,
  output logic                core_start_o,
  output logic                core_work_o,
  output logic                core_first_o,
  output logic [XLEN-1:0]     core_l_o,
  output logic [16*SLEN-1:0]  core_x_o,
  input  logic [8*SLEN-1:0]   core_y_i,
  output logic                busy_o,
  output logic [CNT_W-1:0]    blk_cnt_o
);
  import bash_hash_params_pkg::*;

  localparam int OW = $clog2(OUT_WORDS);
  localparam int CW = $clog2(CORE_CYCLES);

  core_st_e          state_q, state_d;
  logic              busy_q, closed_q;
  logic [XLEN-1:0]   l_q;
  logic [CW-1:0]     cyc_q;
  logic [OW-1:0]     oc_q, wsel;
  logic [CNT_W-1:0]  blk_cnt_q;
  logic [8*SLEN-1:0] y_q;
  logic              wr_full, rd_full, rd_last, rd_done, accept, out_done;

  assign s_ready_o    = !wr_full && !closed_q;
  assign accept       = s_valid_i && s_ready_o;
  assign core_prep_o  = accept && !busy_q;
  assign core_first_o = core_start_o && (blk_cnt_q == '0);
  assign core_l_o     = l_q;
  assign busy_o       = busy_q;
  assign blk_cnt_o    = blk_cnt_q;

  bash_hash_blk_buf #(.XLEN(XLEN), .IN_WORDS(IN_WORDS)) u_blk_buf (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .wr_en   (accept),
    .wr_data (s_data_i),
    .wr_last (s_last_i),
    .rd_done (rd_done),
    .wr_full (wr_full),
    .rd_full (rd_full),
    .rd_last (rd_last),
    .rd_blk  (core_x_o)
  );

  always_comb begin
    state_d      = state_q;
    core_start_o = 1'b0;
    core_work_o  = 1'b0;
    rd_done      = 1'b0;
    m_valid_o    = 1'b0;
    m_last_o     = 1'b0;
    out_done     = 1'b0;
    case (state_q)
      C_IDLE: if (rd_full) begin
        core_start_o = 1'b1;
        state_d      = C_WORK;
      end
      C_WORK: begin
        core_work_o = 1'b1;
        if (cyc_q == CW'(CORE_CYCLES - 1)) begin
          rd_done = 1'b1;
          state_d = rd_last ? C_OUT : C_IDLE;
        end
      end
      C_OUT: begin
        m_valid_o = 1'b1;
        m_last_o  = (oc_q == OW'(OUT_WORDS - 1));
        if (m_ready_i && m_last_o) begin
          out_done = 1'b1;
          state_d  = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Lane y0 sits in the MSBs; even words carry the low half of lane j/2.
  assign wsel     = {~oc_q[OW-1:1], oc_q[0]};
  assign m_data_o = m_valid_o ? y_q[wsel*XLEN +: XLEN] : '0;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= C_IDLE;
      busy_q    <= 1'b0;
      closed_q  <= 1'b0;
      l_q       <= '0;
      cyc_q     <= '0;
      oc_q      <= '0;
      blk_cnt_q <= '0;
      y_q       <= '0;
    end else begin
      state_q <= state_d;
      if (core_prep_o) begin
        l_q    <= cfg_l_i;
        busy_q <= 1'b1;
      end
      if (accept && s_last_i) closed_q <= 1'b1;
      cyc_q <= (core_work_o && !rd_done) ? cyc_q + 1'b1 : '0;
      if (rd_done) begin
        if (blk_cnt_q != '1) blk_cnt_q <= blk_cnt_q + 1'b1;
        if (rd_last) y_q <= core_y_i;
      end
      if (m_valid_o && m_ready_i) oc_q <= out_done ? '0 : oc_q + 1'b1;
      if (out_done) begin
        busy_q    <= 1'b0;
        closed_q  <= 1'b0;
        blk_cnt_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bash_hash_stream_ctrl.sv
// Directed bench for bash_hash_stream_ctrl: hand-derived latencies, block
// contents and digest ordering, checked with immediate assertions.
module tb_bash_hash_stream_ctrl;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic [31:0]   cfg_l, s_data, m_data, core_l;
  logic          s_valid, s_last, s_ready, m_valid, m_last, m_ready;
  logic          prep, start, work, first, busy;
  logic [1023:0] core_x;
  logic [511:0]  core_y;
  logic [15:0]   blk_cnt;

  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int n_prep = 0, n_start = 0, n_work = 0, n_stall = 0, n_out = 0, n_unstable = 0, acc_cyc = 0;
  int            st_cyc[0:15];
  logic          st_first[0:15];
  logic [1023:0] st_x[0:15];
  logic [31:0]   o_data[0:127];
  logic          o_last[0:127];
  logic          hold = 1'b0;
  logic [31:0]   hold_d = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bash_hash_stream_ctrl dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .cfg_l_i(cfg_l),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last), .m_ready_i(m_ready),
    .core_prep_o(prep), .core_start_o(start), .core_work_o(work), .core_first_o(first),
    .core_l_o(core_l), .core_x_o(core_x), .core_y_i(core_y),
    .busy_o(busy), .blk_cnt_o(blk_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Samples the current cycle after inputs have settled; transfers seen here
  // complete at the next rising edge.
  task automatic mon();
    if (prep) n_prep++;
    if (start && n_start < 16) begin
      st_cyc[n_start] = cyc; st_first[n_start] = first; st_x[n_start] = core_x; n_start++;
    end
    if (work) n_work++;
    if (s_valid && !s_ready) n_stall++;
    if (s_valid && s_ready) acc_cyc = cyc;
    if (hold && m_valid && m_data !== hold_d) n_unstable++;
    hold = m_valid && !m_ready;
    hold_d = m_data;
    if (m_valid && m_ready && n_out < 128) begin
      o_data[n_out] = m_data; o_last[n_out] = m_last; n_out++;
    end
  endtask

  task automatic tick();
    #1; mon(); @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && n < 500) begin tick(); n++; end
    chk("send_timeout", 32'(n < 500), 1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_mvalid(output int c);
    int n = 0;
    while (!m_valid && n < 200) begin tick(); n++; end
    chk("mvalid_timeout", 32'(m_valid), 1);
    c = cyc;
  endtask

  task automatic wait_out(input int target, input logic toggle);
    int n = 0;
    while (n_out < target && n < 400) begin
      if (toggle) m_ready = (n % 4 == 0) || (n % 4 == 3);
      tick(); n++;
    end
    m_ready = 1'b1;
    chk("out_timeout", 32'(n_out >= target), 1);
  endtask

  // Core result lanes are built so that digest word j reads 0xC000_0000 | j.
  task automatic chk_digest(input int base);
    for (int j = 0; j < 16; j++) begin
      chk("dig_word", o_data[base+j], 32'hC000_0000 | 32'(j));
      chk("dig_last", 32'(o_last[base+j]), 32'(j == 15));
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp, bs, bw, bo, bst, bu, t, mv;
    s_valid = 0; s_last = 0; s_data = '0; cfg_l = '0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      core_y[(7-i)*64 +: 64] = {32'hC000_0000 | 32'(2*i+1), 32'hC000_0000 | 32'(2*i)};
    @(negedge clk);
    tick(); tick();
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_work",    32'(work), 0);
    chk("rst_core_l",  core_l, 0);
    chk("rst_blk_cnt", 32'(blk_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Single full block, data = index
    cfg_l = 32'd128;
    bp = n_prep; bs = n_start; bw = n_work; bo = n_out;
    for (int k = 0; k < 32; k++) send(32'(k), k == 31);
    t = acc_cyc;
    wait_mvalid(mv);
    chk("a_prep_cnt",  32'(n_prep - bp), 1);
    chk("a_start_lat", 32'(st_cyc[bs] - t), 1);
    chk("a_first",     32'(st_first[bs]), 1);
    chk("a_x_lo",      st_x[bs][31:0], 0);
    chk("a_x_hi",      st_x[bs][1023:992], 31);
    chk("a_core_l",    core_l, 128);
    chk("a_mv_lat",    32'(mv - t), 26);
    chk("a_blk_cnt",   32'(blk_cnt), 1);
    wait_out(bo + 16, 1'b0);
    chk("a_work_cyc",  32'(n_work - bw), 24);
    chk_digest(bo);
    chk("a_busy_clr",  32'(busy), 0);
    chk("a_cnt_clr",   32'(blk_cnt), 0);

    // Three blocks back-to-back
    bp = n_prep; bs = n_start; bo = n_out; bst = n_stall;
    for (int k = 0; k < 96; k++) send(32'h100 + 32'(k), k == 95);
    t = acc_cyc;
    wait_mvalid(mv);
    chk("b_prep_cnt",  32'(n_prep - bp), 1);
    chk("b_starts",    32'(n_start - bs), 3);
    chk("b_stall",     32'(n_stall - bst), 0);
    chk("b_space01",   32'(st_cyc[bs+1] - st_cyc[bs]), 32);
    chk("b_space12",   32'(st_cyc[bs+2] - st_cyc[bs+1]), 32);
    chk("b_first0",    32'(st_first[bs]), 1);
    chk("b_first1",    32'(st_first[bs+1]), 0);
    chk("b_first2",    32'(st_first[bs+2]), 0);
    chk("b_x1_lo",     st_x[bs+1][31:0], 32'h120);
    chk("b_x2_hi",     st_x[bs+2][1023:992], 32'h15F);
    chk("b_blk_cnt",   32'(blk_cnt), 3);
    chk("b_mv_lat",    32'(mv - t), 26);
    wait_out(bo + 16, 1'b0);
    chk_digest(bo);

    // Short block (last on word 4), then a word held off during the digest
    bp = n_prep; bs = n_start; bw = n_work; bo = n_out;
    for (int k = 0; k < 5; k++) send(32'hA0 + 32'(k), k == 4);
    s_valid = 1'b1; s_data = 32'hDEAD; s_last = 1'b1;
    wait_mvalid(mv);
    chk("c_rdy_blk",   32'(s_ready), 0);
    chk("c_busy",      32'(busy), 1);
    chk("c_starts",    32'(n_start - bs), 1);
    chk("c_x_w0",      st_x[bs][31:0], 32'hA0);
    chk("c_x_w3",      st_x[bs][127:96], 32'hA3);
    chk("c_x_w4",      st_x[bs][159:128], 32'hA4);
    chk("c_x_w5",      st_x[bs][191:160], 0);
    chk("c_x_w31",     st_x[bs][1023:992], 0);
    wait_out(bo + 16, 1'b0);
    chk("c_work_cyc",  32'(n_work - bw), 24);
    chk_digest(bo);
    chk("c_busy_clr",  32'(busy), 0);
    chk("c_blocked",   32'(n_prep - bp), 1);
    chk("c_rdy_back",  32'(s_ready), 1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("f_prep",      32'(n_prep - bp), 2);

    // Single-word message drained with m_ready toggling 1,0,0,1
    bo = n_out; bu = n_unstable;
    wait_mvalid(mv);
    chk("d_first",     32'(st_first[bs+1]), 1);
    chk("d_x_w0",      st_x[bs+1][31:0], 32'hDEAD);
    chk("d_x_w1",      st_x[bs+1][63:32], 0);
    chk("d_x_w31",     st_x[bs+1][1023:992], 0);
    wait_out(bo + 16, 1'b1);
    chk_digest(bo);
    chk("d_stable",    32'(n_unstable - bu), 0);
    chk("d_busy_clr",  32'(busy), 0);

    // Reset during work cycle 10, then a fresh message
    bw = n_work;
    send(32'h77, 1'b1);
    t = 0;
    while (n_work - bw < 10 && t < 100) begin tick(); t++; end
    chk("e_work_on",   32'(work), 1);
    rst_n = 1'b0;
    #1;
    chk("e_rst_work",  32'(work), 0);
    chk("e_rst_rdy",   32'(s_ready), 1);
    chk("e_rst_busy",  32'(busy), 0);
    chk("e_rst_mval",  32'(m_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    cfg_l = 32'h55;
    bp = n_prep; bs = n_start; bo = n_out;
    for (int k = 0; k < 32; k++) send(32'(k), k == 31);
    t = acc_cyc;
    wait_mvalid(mv);
    chk("e_prep_cnt",  32'(n_prep - bp), 1);
    chk("e_start_lat", 32'(st_cyc[bs] - t), 1);
    chk("e_first",     32'(st_first[bs]), 1);
    chk("e_core_l",    core_l, 32'h55);
    chk("e_x_hi",      st_x[bs][1023:992], 31);
    chk("e_mv_lat",    32'(mv - t), 26);
    wait_out(bo + 16, 1'b0);
    chk_digest(bo);
    chk("e_busy_clr",  32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
